// File: rtl/csp_pkg.sv
// rtl/csp_pkg.sv - shared constants and types for CSP channel primitives
package csp_pkg;

    localparam int CSP_WIDTH    = 32;
    localparam int CSP_DEST_BIT = 31;

    typedef enum logic {
        DEST_0 = 1'b0,
        DEST_1 = 1'b1
    } dest_e;

endpackage

// File: rtl/channel_fifo.sv
// rtl/channel_fifo.sv - registered FIFO decoupling one channel output
module channel_fifo
    import csp_pkg::*;
#(
    parameter int WIDTH = CSP_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/router_1to2.sv
// rtl/router_1to2.sv - steers each accepted word to one of two FIFO-decoupled outputs
module router_1to2
    import csp_pkg::*;
#(
    parameter int WIDTH    = CSP_WIDTH,
    parameter int DEST_BIT = CSP_DEST_BIT,
    parameter int DEPTH    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] receive_data0,
    input  logic             receive_request0,
    output logic             receive_valid0,
    output logic [WIDTH-1:0] send_data0,
    output logic [WIDTH-1:0] send_data1,
    output logic             send_request0,
    output logic             send_request1,
    input  logic             send_valid0,
    input  logic             send_valid1
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    dest_e            dest;
    logic             full0, full1;
    logic             empty0, empty1;
    logic [CNT_W-1:0] count0, count1;
    logic             push0, push1;
    logic             pop0, pop1;

    assign dest = dest_e'(receive_data0[DEST_BIT]);

    // Acceptance uses only registered fullness, never send_valid, so a full
    // FIFO being drained this cycle still refuses until the next cycle.
    assign receive_valid0 = reset && receive_request0 &&
                            !((dest == DEST_1) ? full1 : full0);

    assign push0 = receive_valid0 && (dest == DEST_0);
    assign push1 = receive_valid0 && (dest == DEST_1);

    assign send_request0 = (count0 != '0);
    assign send_request1 = (count1 != '0);
    assign pop0          = !empty0 && send_valid0;
    assign pop1          = !empty1 && send_valid1;

    channel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .reset     (reset),
        .push      (push0),
        .push_data (receive_data0),
        .pop       (pop0),
        .head_data (send_data0),
        .full      (full0),
        .empty     (empty0),
        .count     (count0)
    );

    channel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .reset     (reset),
        .push      (push1),
        .push_data (receive_data0),
        .pop       (pop1),
        .head_data (send_data1),
        .full      (full1),
        .empty     (empty1),
        .count     (count1)
    );

endmodule

// File: tb/tb_router_1to2.sv
// tb/tb_router_1to2.sv - randomized self-checking bench for router_1to2
module tb_router_1to2;

    localparam int WIDTH    = 32;
    localparam int DEST_BIT = 31;
    localparam int DEPTH    = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] receive_data0 = '0;
    logic             receive_request0 = 1'b0;
    logic             receive_valid0;
    logic [WIDTH-1:0] send_data0, send_data1;
    logic             send_request0, send_request1;
    logic             send_valid0 = 1'b0;
    logic             send_valid1 = 1'b0;

    router_1to2 #(.WIDTH(WIDTH), .DEST_BIT(DEST_BIT), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .receive_data0    (receive_data0),
        .receive_request0 (receive_request0),
        .receive_valid0   (receive_valid0),
        .send_data0       (send_data0),
        .send_data1       (send_data1),
        .send_request0    (send_request0),
        .send_request1    (send_request1),
        .send_valid0      (send_valid0),
        .send_valid1      (send_valid1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: one queue of pending words per output.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];

    logic             obs_rv, obs_r0, obs_r1;
    logic [WIDTH-1:0] obs_d0, obs_d1;
    logic             exp_rv, exp_r0, exp_r1;
    logic [WIDTH-1:0] exp_d0, exp_d1;

    task automatic drive_cycle(input logic [WIDTH-1:0] d, input logic rq,
                               input logic v0, input logic v1);
        receive_data0    = d;
        receive_request0 = rq;
        send_valid0      = v0;
        send_valid1      = v1;
        #1;
        obs_rv = receive_valid0;
        obs_r0 = send_request0;
        obs_r1 = send_request1;
        obs_d0 = send_data0;
        obs_d1 = send_data1;
        if (d[DEST_BIT]) exp_rv = rq && (q1.size() < DEPTH);
        else             exp_rv = rq && (q0.size() < DEPTH);
        exp_r0 = (q0.size() != 0);
        exp_r1 = (q1.size() != 0);
        exp_d0 = exp_r0 ? q0[0] : '0;
        exp_d1 = exp_r1 ? q1[0] : '0;
        @(posedge clk);
        if (exp_r0 && v0) void'(q0.pop_front());
        if (exp_r1 && v1) void'(q1.pop_front());
        if (exp_rv) begin
            if (d[DEST_BIT]) q1.push_back(d);
            else             q0.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        receive_data0    = 32'h0000_0005;
        receive_request0 = 1'b1;
        send_valid0      = 1'b1;
        send_valid1      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({receive_valid0, send_request0, send_request1, send_data0, send_data1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rv=%b r0=%b r1=%b d0=%h d1=%h, required all zero",
                     receive_valid0, send_request0, send_request1, send_data0, send_data1);
        end
        receive_request0 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({dut.u_fifo0.count, dut.u_fifo1.count} !== '0) begin
            errors++;
            $display("FAIL reset_counts: count0=%0d count1=%0d, required 0 0",
                     dut.u_fifo0.count, dut.u_fifo1.count);
        end
    endtask

    task automatic test_single();
        drive_cycle(32'h0000_0005, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs_rv !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: rv=%b, required 1", obs_rv);
        end
        drive_cycle('0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({obs_r0, obs_d0, obs_r1} !== {1'b1, 32'h0000_0005, 1'b0}) begin
            errors++;
            $display("FAIL single_forward: r0=%b d0=%h r1=%b, required 1 00000005 0",
                     obs_r0, obs_d0, obs_r1);
        end
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] words [3];
        logic             req_rv [3];
        int               accept_at;
        words  = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0003};
        req_rv = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(words[i], 1'b1, 1'b1, 1'b0);
            checks++;
            if (obs_rv !== req_rv[i] || obs_rv !== exp_rv) begin
                errors++;
                $display("FAIL stall_fill[%0d]: rv=%b, required %b", i, obs_rv, req_rv[i]);
            end
        end
        // In-order sender keeps offering the blocked word; the out-0 word waits behind it.
        drive_cycle(32'h8000_0003, 1'b1, 1'b1, 1'b0);
        checks++;
        if (obs_rv !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: rv=%b, required 0", obs_rv);
        end
        accept_at = -1;
        for (int i = 0; i < 6 && accept_at < 0; i++) begin
            drive_cycle(32'h8000_0003, 1'b1, 1'b1, 1'b1);
            checks++;
            if ({obs_rv, obs_r0, obs_r1, obs_d0, obs_d1} !== {exp_rv, exp_r0, exp_r1, exp_d0, exp_d1}) begin
                errors++;
                $display("FAIL stall_release[%0d]: rv=%b r1=%b d1=%h, required %b %b %h",
                         i, obs_rv, obs_r1, obs_d1, exp_rv, exp_r1, exp_d1);
            end
            if (obs_rv) accept_at = i;
        end
        checks++;
        if (accept_at !== 1) begin
            errors++;
            $display("FAIL stall_accept_cycle: accepted at try %0d, required 1", accept_at);
        end
        drive_cycle(32'h0000_0009, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive_cycle('0, 1'b0, 1'b1, 1'b1);
            checks++;
            if ({obs_r0, obs_r1, obs_d0, obs_d1} !== {exp_r0, exp_r1, exp_d0, exp_d1}) begin
                errors++;
                $display("FAIL stall_drain[%0d]: r0=%b r1=%b d0=%h d1=%h, required %b %b %h %h",
                         i, obs_r0, obs_r1, obs_d0, obs_d1, exp_r0, exp_r1, exp_d0, exp_d1);
            end
        end
    endtask

    task automatic test_full_pop();
        drive_cycle(32'h0000_0011, 1'b1, 1'b0, 1'b1);
        drive_cycle(32'h0000_0012, 1'b1, 1'b0, 1'b1);
        drive_cycle(32'h0000_0013, 1'b1, 1'b1, 1'b1);
        checks++;
        if (obs_rv !== 1'b0 || obs_d0 !== 32'h0000_0011) begin
            errors++;
            $display("FAIL full_pop_refuse: rv=%b d0=%h, required 0 00000011", obs_rv, obs_d0);
        end
        drive_cycle(32'h0000_0013, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_rv !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_accept: rv=%b, required 1", obs_rv);
        end
        checks++;
        if (dut.u_fifo0.count !== 2'd2 || q0.size() != 2) begin
            errors++;
            $display("FAIL full_pop_count: count0=%0d, required 2", dut.u_fifo0.count);
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle('0, 1'b0, 1'b1, 1'b1);
            checks++;
            if ({obs_r0, obs_d0} !== {exp_r0, exp_d0}) begin
                errors++;
                $display("FAIL full_pop_drain[%0d]: r0=%b d0=%h, required %b %h",
                         i, obs_r0, obs_d0, exp_r0, exp_d0);
            end
        end
    endtask

    task automatic test_alternate();
        logic [WIDTH-1:0] d;
        int               max_count;
        max_count = 0;
        for (int i = 0; i < 18; i++) begin
            d = 32'h0000_0100 + 32'(i);
            d[DEST_BIT] = i[0];
            drive_cycle(d, (i < 16), 1'b1, 1'b1);
            checks++;
            if ({obs_rv, obs_r0, obs_r1, obs_d0, obs_d1} !== {exp_rv, exp_r0, exp_r1, exp_d0, exp_d1}) begin
                errors++;
                $display("FAIL alternate[%0d]: rv=%b d0=%h d1=%h, required %b %h %h",
                         i, obs_rv, obs_d0, obs_d1, exp_rv, exp_d0, exp_d1);
            end
            if (int'(dut.u_fifo0.count) > max_count) max_count = int'(dut.u_fifo0.count);
            if (int'(dut.u_fifo1.count) > max_count) max_count = int'(dut.u_fifo1.count);
        end
        checks++;
        if (max_count > 1) begin
            errors++;
            $display("FAIL alternate_max_count: max=%0d, required at most 1", max_count);
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(32'h0000_0021, 1'b1, 1'b0, 1'b0);
        drive_cycle(32'h8000_0022, 1'b1, 1'b0, 1'b0);
        drive_cycle(32'h0000_0023, 1'b1, 1'b0, 1'b0);
        drive_cycle(32'h8000_0024, 1'b1, 1'b0, 1'b0);
        receive_data0    = 32'h0000_0025;
        receive_request0 = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({receive_valid0, send_request0, send_request1, send_data0, send_data1} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: rv=%b r0=%b r1=%b d0=%h d1=%h, required all zero",
                     receive_valid0, send_request0, send_request1, send_data0, send_data1);
        end
        q0.delete();
        q1.delete();
        receive_request0 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({dut.u_fifo0.count, dut.u_fifo1.count, send_request0, send_request1} !== '0) begin
            errors++;
            $display("FAIL async_reset_counts: count0=%0d count1=%0d, required 0 0",
                     dut.u_fifo0.count, dut.u_fifo1.count);
        end
        drive_cycle(32'h8000_0026, 1'b1, 1'b1, 1'b1);
        drive_cycle('0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({obs_r0, obs_r1, obs_d0, obs_d1} !== {1'b0, 1'b1, 32'h0, 32'h8000_0026}) begin
            errors++;
            $display("FAIL async_reset_fresh: r0=%b r1=%b d0=%h d1=%h, required 0 1 0 80000026",
                     obs_r0, obs_r1, obs_d0, obs_d1);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] word;
        logic             pending;
        int               bias0, bias1;
        pending = 1'b0;
        word    = '0;
        bias0   = 50;
        bias1   = 50;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc % 1000 == 0) begin
                bias0 = $urandom_range(95, 5);
                bias1 = $urandom_range(95, 5);
            end
            if (!pending && $urandom_range(3) != 0) begin
                word    = $urandom;
                pending = 1'b1;
            end
            drive_cycle(pending ? word : WIDTH'($urandom), pending,
                        $urandom_range(99) < bias0, $urandom_range(99) < bias1);
            checks++;
            if ({obs_rv, obs_r0, obs_r1, obs_d0, obs_d1} !== {exp_rv, exp_r0, exp_r1, exp_d0, exp_d1}) begin
                errors++;
                $display("FAIL random[%0d]: rv=%b r0=%b r1=%b d0=%h d1=%h, required %b %b %b %h %h",
                         cyc, obs_rv, obs_r0, obs_r1, obs_d0, obs_d1,
                         exp_rv, exp_r0, exp_r1, exp_d0, exp_d1);
            end
            checks++;
            if (int'(dut.u_fifo0.count) != q0.size() || int'(dut.u_fifo1.count) != q1.size()) begin
                errors++;
                $display("FAIL random_count[%0d]: count0=%0d count1=%0d, required %0d %0d",
                         cyc, dut.u_fifo0.count, dut.u_fifo1.count, q0.size(), q1.size());
            end
            if (exp_rv) pending = 1'b0;
        end
        for (int i = 0; i < DEPTH + 1; i++) drive_cycle('0, 1'b0, 1'b1, 1'b1);
        drive_cycle('0, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({obs_r0, obs_r1} !== 2'b00 || q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL random_final_empty: r0=%b r1=%b, required 0 0", obs_r0, obs_r1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_full_pop();
        test_alternate();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/router_1to2.md
# router_1to2

Two-way channel splitter: the fan-out counterpart of the 2-to-1 arbiter on the request/valid channel protocol. It accepts words from one sending channel and steers each word to one of two output channels based on a destination bit carried in the word. Each output is decoupled by a small FIFO, so a stalled receiver does not block the other output until the stalled FIFO fills. It sits between a producer process and two consumer processes in the CSP fabric.

## Interface
Parameters:
- WIDTH, 32, channel data width.
- DEST_BIT, 31, index of the bit in receive_data0 that selects the output (0 → send 0, 1 → send 1).
- DEPTH, 2, entries per output FIFO; must be a power of two, minimum 2.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- receive_data0  in  WIDTH  incoming word.
- receive_request0  in  1  sender offers receive_data0 this cycle.
- receive_valid0  out  1  word accepted this cycle.
- send_data0 / send_data1  out  WIDTH  head word of output FIFO 0 / 1.
- send_request0 / send_request1  out  1  output FIFO 0 / 1 holds a word.
- send_valid0 / send_valid1  in  1  receiver 0 / 1 takes the head word this cycle.

## Operation
- Channel rule, both sides: a transfer happens in a cycle where request and valid are both 1. A request holds its data stable until accepted.
- dest = receive_data0[DEST_BIT]. The full word, including DEST_BIT, is forwarded unchanged.
- receive_valid0 = receive_request0 && !full[dest]. It is combinational from the request, the data bit and registered FIFO state only. It never depends on send_valid*.
- On accept, the word is pushed into FIFO[dest]. The other FIFO is untouched.
- send_requestN = (countN != 0).
- send_dataN = head of FIFO N when nonempty, else all zeros.
- Pop of FIFO N happens when send_requestN && send_validN.
- Each FIFO has a read pointer and a write pointer of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits ranging over 0..DEPTH.
- Count update per edge: push only → +1; pop only → −1; push and pop together → unchanged, both take effect.
- Full FIFO with a pop in the same cycle: the push is still refused (receive_valid0 = 0). The entry frees one cycle later. This deliberately removes the combinational path from send_valid to receive_valid.
- send_valid asserted with send_request low is ignored: no pointer or count change.
- No reordering within one output. Words to different outputs may leave in any relative order.

## Timing
- Latency from accept at edge k to send_requestN = 1 happens after edge k, so the word is visible in cycle k+1.
- Throughput: one word per cycle in. Each output pops one word per cycle. An output sustains full rate with DEPTH ≥ 2.
- Reset asserted, at any time including mid-transfer:
  - all pointers and counts go to 0 immediately;
  - send_request* = 0 and send_data* = 0;
  - receive_valid0 = 0 while reset is low.
  - Stored words are discarded.
- First accept is possible in the first cycle after reset is released.

## Structure
- Shared package csp_pkg holds the default channel width (32) and the default destination-bit constant. The arbiter and later channel primitives also use these.
- One sub-module, channel_fifo, parameterized by WIDTH and DEPTH:
  - push/pop/full/empty/count interface;
  - registered storage;
  - head-data output zeroed when empty;
  - asynchronous active-low reset.
- router_1to2 instantiates channel_fifo twice and adds the dest decode and accept logic.

## Test plan
- After reset, offer 0x0000_0005 (bit31 = 0) with send_valid* = 1:
  - receive_valid0 = 1 in the same cycle;
  - next cycle send_request0 = 1 and send_data0 = 0x0000_0005;
  - send_request1 stays 0.
- Stall output 1 (send_valid1 = 0) and offer 0x8000_0001, 0x8000_0002, 0x8000_0003:
  - the first two are accepted and the third sees receive_valid0 = 0;
  - a following 0x0000_0009 is still blocked (in-order sender).
  - Release send_valid1: 0x8000_0001 then 0x8000_0002 drain in order, then 0x8000_0003 is accepted.
- Full FIFO 0 with send_valid0 = 1 and a new bit31 = 0 request:
  - receive_valid0 = 0 that cycle;
  - accepted the next cycle, count stays at 2.
- Alternate destinations every cycle for 16 words with both receivers always valid:
  - each output sees its 8 words in order;
  - count never exceeds 1.
- Assert reset low asynchronously between edges with both FIFOs holding 2 words:
  - send_request* and send_data* go to 0 before the next edge;
  - after release, the counts are 0 and no stale word reappears.
- Random request/valid stimulus over 10,000 cycles against a scoreboard:
  - no loss, duplication or per-output reordering;
  - count stays within 0..DEPTH.
